act_fetcher: RTL and testbench
==============================

ACT_FETCHER -- requirements
Module: act_fetcher

Interface
REQ-001 SHALL have parameter TAMANO_ADDRESS, default 21: width of activation addresses.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that launches a fetch run.
REQ-006 SHALL have port base_addr  input  TAMANO_ADDRESS  first activation address.
REQ-007 SHALL have port cuenta  input  16  number of activations to fetch.
REQ-008 SHALL have port stride  input  8  address increment between activations.
REQ-009 SHALL have port busy  output  1  high from accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the run has completed and drained.
REQ-011 SHALL have port cache_req  output  1  read request strobe to act_cache.
REQ-012 SHALL have port cache_address  output  TAMANO_ADDRESS  address presented with cache_req.
REQ-013 SHALL have port cache_lectura_escritura  output  1  tied to 1 (read).
REQ-014 SHALL have port cache_activacion  input  16  read data from the cache.
REQ-015 SHALL have port cache_valido  input  1  cache data valid, one-cycle pulse.
REQ-016 SHALL have port act_out  output  16  activation to the consumer (MAC array).
REQ-017 SHALL have port act_valid  output  1  act_out is valid.
REQ-018 SHALL have port act_ready  input  1  consumer accepts act_out when act_valid and act_ready are both high.

Function
REQ-019 SHALL implement an FSM with states IDLE, REQ, WAIT and DRAIN.
REQ-020 IDLE: on start, SHALL latch base_addr, cuenta and stride, clear the index and set busy; if cuenta is 0 SHALL go to DRAIN, otherwise SHALL go to REQ.
REQ-021 SHALL ignore start while busy is high.
REQ-022 REQ: SHALL assert cache_req for exactly one cycle with cache_address equal to base plus index times stride, modulo 2^TAMANO_ADDRESS, and only when FIFO occupancy is below FIFO_DEPTH; otherwise it SHALL stall in REQ with cache_req low; it SHALL go to WAIT after issuing.
REQ-023 SHALL keep at most one cache request outstanding at any time.
REQ-024 WAIT: on cache_valido, SHALL push cache_activacion into the FIFO and increment the index; if the index then equals cuenta SHALL go to DRAIN, otherwise SHALL go to REQ.
REQ-025 SHALL ignore cache_valido in any state other than WAIT.
REQ-026 DRAIN: when the FIFO is empty, SHALL pulse done for one cycle, deassert busy in that same cycle and return to IDLE.
REQ-027 SHALL drive the FIFO head on act_out and SHALL assert act_valid whenever the FIFO is non-empty, in every state.
REQ-028 SHALL hold act_out and act_valid stable while act_valid is high and act_ready is low.
REQ-029 On a simultaneous push and pop, SHALL leave occupancy unchanged and preserve order, including when the FIFO is full.
REQ-030 Latency: with act_ready high, data SHALL appear on act_out one cycle after the cache_valido pulse.
REQ-031 A zero-length run (cuenta of 0) SHALL pulse done two cycles after start and SHALL issue no cache_req.

Reset
REQ-032 While rst is high: state SHALL be IDLE; busy, done, cache_req and act_valid SHALL be 0; cache_address and act_out SHALL be 0; the FIFO SHALL be empty; the index and latched run parameters SHALL be 0.
REQ-033 A reset mid-run SHALL abort the run: buffered data is discarded and a late cache_valido is ignored.

Structure
REQ-034 A shared package act_pkg SHALL hold the FSM state enum, TAMANO_ADDRESS, and ACT_WIDTH (16).
REQ-035 The FIFO SHALL be a separate sub-module act_fifo, parameterised by ACT_WIDTH and FIFO_DEPTH.

Verification
REQ-036 Basic run: base 0x00100, cuenta 4, stride 1, cache answering 2 cycles after each request with data 0x1111 to 0x4444, act_ready held high. Required: addresses 0x00100 to 0x00103; act_out delivers 0x1111, 0x2222, 0x3333, 0x4444 in order; done pulses once.
REQ-037 Address wrap: base 0x1FFFE, stride 3, cuenta 3. Required: addresses 0x1FFFE, 0x00001, 0x00004.
REQ-038 Backpressure: FIFO_DEPTH 4, cuenta 8, act_ready low. Required: exactly 4 requests, then cache_req stays low. Raising act_ready must release the remaining 4 requests, deliver 8 words in order and then pulse done.
REQ-039 Zero length: cuenta 0. Required: no cache_req; done pulses 2 cycles after start.
REQ-040 Abort and ignore: rst asserted while in WAIT with 2 words buffered. Required: act_valid drops immediately, and a subsequent cache_valido pulse pushes nothing. A start pulse mid-run must leave the address sequence unchanged.

Source files
------------

// File: rtl/act_pkg.sv
// Shared types and constants for the activation fetcher and its output buffer.
package act_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int TAMANO_ADDRESS = 21;
   localparam int ACT_WIDTH      = 16;

endpackage

// File: rtl/act_fifo.sv
// Small power-of-two output buffer between the cache read path and the consumer.
// Head is always visible; a pop and a push in the same cycle keep occupancy.
module act_fifo #(
   parameter int ACT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [ACT_WIDTH-1:0] push_data,
   input  logic                 pop,
   output logic [ACT_WIDTH-1:0] head,
   output logic                 empty,
   output logic                 full
);
   import act_pkg::*;

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   logic [ACT_WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_r;
   logic [PW-1:0]        rd_ptr_r;
   logic [PW:0]          count_r;
   logic                 do_pop_s;
   logic                 do_push_s;

   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_pop_s  = pop && (count_r != {(PW+1){1'b0}});
   assign do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);

   assign head  = mem_r[rd_ptr_r];
   assign empty = (count_r == {(PW+1){1'b0}});
   assign full  = (count_r == FULL_COUNT);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {ACT_WIDTH{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + COUNT_ONE;
            2'b01:   count_r <= count_r - COUNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/act_fetcher.sv
// Fetches a strided run of activations from act_cache, one request at a time,
// and streams them to the MAC array through a small ready/valid buffer.
module act_fetcher #(
   parameter int TAMANO_ADDRESS = act_pkg::TAMANO_ADDRESS,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [TAMANO_ADDRESS-1:0]     base_addr,
   input  logic [15:0]                   cuenta,
   input  logic [7:0]                    stride,
   output logic                          busy,
   output logic                          done,
   output logic                          cache_req,
   output logic [TAMANO_ADDRESS-1:0]     cache_address,
   output logic                          cache_lectura_escritura,
   input  logic [act_pkg::ACT_WIDTH-1:0] cache_activacion,
   input  logic                          cache_valido,
   output logic [act_pkg::ACT_WIDTH-1:0] act_out,
   output logic                          act_valid,
   input  logic                          act_ready
);
   import act_pkg::*;

   state_t                    state_r, state_s;
   logic [TAMANO_ADDRESS-1:0] base_r, base_s;
   logic [15:0]               cuenta_r, cuenta_s;
   logic [15:0]               index_r, index_s;
   logic [7:0]                stride_r, stride_s;
   logic                      busy_r, busy_s;
   logic                      done_r, done_s;
   logic                      req_r, req_s;
   logic [TAMANO_ADDRESS-1:0] addr_r, addr_s;
   logic [23:0]               offset_s;
   logic                      push_s;
   logic                      empty_s;
   logic                      full_s;

   act_fifo #(
      .ACT_WIDTH  (ACT_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (cache_activacion),
      .pop       (act_ready),
      .head      (act_out),
      .empty     (empty_s),
      .full      (full_s)
   );

   assign busy                    = busy_r;
   assign done                    = done_r;
   assign cache_req               = req_r;
   assign cache_address           = addr_r;
   assign cache_lectura_escritura = 1'b1;
   assign act_valid               = !empty_s;

   // Next-state and next-register values; the address wraps at the bus width.
   always_comb begin
      offset_s = {8'd0, index_r} * {16'd0, stride_r};
      state_s  = state_r;
      base_s   = base_r;
      cuenta_s = cuenta_r;
      index_s  = index_r;
      stride_s = stride_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      req_s    = 1'b0;
      addr_s   = addr_r;
      push_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               base_s   = base_addr;
               cuenta_s = cuenta;
               stride_s = stride;
               index_s  = 16'd0;
               busy_s   = 1'b1;
               state_s  = (cuenta == 16'd0) ? ST_DRAIN : ST_REQ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!full_s) begin
               req_s   = 1'b1;
               addr_s  = base_r + TAMANO_ADDRESS'(offset_s);
               state_s = ST_WAIT;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (cache_valido) begin
               push_s  = 1'b1;
               index_s = index_r + 16'd1;
               state_s = (index_s == cuenta_r) ? ST_DRAIN : ST_REQ;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (empty_s) begin
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Run-control registers; reset discards any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         base_r   <= {TAMANO_ADDRESS{1'b0}};
         cuenta_r <= 16'd0;
         index_r  <= 16'd0;
         stride_r <= 8'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         req_r    <= 1'b0;
         addr_r   <= {TAMANO_ADDRESS{1'b0}};
      end else begin
         state_r  <= state_s;
         base_r   <= base_s;
         cuenta_r <= cuenta_s;
         index_r  <= index_s;
         stride_r <= stride_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         req_r    <= req_s;
         addr_r   <= addr_s;
      end
   end

endmodule

// File: tb/tb_act_fetcher.sv
// Directed bench for act_fetcher: a queue model of the output buffer checked every
// cycle, a 2-cycle cache responder, and literal expectations for each scenario.
module tb_act_fetcher;

   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [15:0]   cuenta;
   logic [7:0]    stride;
   logic          busy, done, cache_req, cache_lectura_escritura;
   logic [AW-1:0] cache_address;
   logic [15:0]   cache_activacion;
   logic          cache_valido;
   logic [15:0]   act_out;
   logic          act_valid;
   logic          act_ready;

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   int            req_count = 0;
   int            pulses   = 0;
   int            done_count = 0;
   int            done_cyc = 0;
   int            start_cyc = 0;
   bit            ignore_resp = 1'b0;
   logic [15:0]   model_q[$];
   logic [15:0]   resp_data[$];
   logic [15:0]   dut_recv[$];
   logic [AW-1:0] addr_seen[$];
   logic [AW-1:0] exp_addr[$];

   act_fetcher #(.TAMANO_ADDRESS(AW), .FIFO_DEPTH(4)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .base_addr               (base_addr),
      .cuenta                  (cuenta),
      .stride                  (stride),
      .busy                    (busy),
      .done                    (done),
      .cache_req               (cache_req),
      .cache_address           (cache_address),
      .cache_lectura_escritura (cache_lectura_escritura),
      .cache_activacion        (cache_activacion),
      .cache_valido            (cache_valido),
      .act_out                 (act_out),
      .act_valid               (act_valid),
      .act_ready               (act_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Buffer model: pops on ready while non-empty, pushes each answered request.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (act_valid === 1'b1 && act_ready === 1'b1) dut_recv.push_back(act_out);
         if (rst) begin
            model_q.delete();
         end else begin
            if (model_q.size() != 0 && act_ready) void'(model_q.pop_front());
            if (cache_valido && !ignore_resp) model_q.push_back(cache_activacion);
         end
      end
   end

   // Per-cycle compare against the model, plus done bookkeeping.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("act_valid", 32'(act_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) chk("act_out", 32'(act_out), 32'(model_q[0]));
            if (done) begin
               done_count++;
               done_cyc = cyc;
               chk("busy_at_done", 32'(busy), 32'd0);
            end
         end
      end
   end

   // Cache responder: answers each request two cycles later with the next table word.
   initial begin
      int  resp_cnt;
      bit  prev_req;
      resp_cnt         = 0;
      prev_req         = 1'b0;
      cache_valido     = 1'b0;
      cache_activacion = 16'h0000;
      forever begin
         @(negedge clk);
         cache_valido = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               cache_valido     = 1'b1;
               cache_activacion = (resp_data.size() != 0) ? resp_data.pop_front() : 16'hDEAD;
               pulses++;
            end
         end
         if (cache_req === 1'b1 && !rst) begin
            chk("one_outstanding", 32'(resp_cnt == 0 && !prev_req), 32'd1);
            addr_seen.push_back(cache_address);
            req_count++;
            resp_cnt = 2;
         end
         prev_req = (cache_req === 1'b1);
      end
   end

   task automatic launch(input logic [AW-1:0] b, input logic [15:0] n, input logic [7:0] s,
                         input logic [15:0] data0);
      logic [AW-1:0] a;
      addr_seen.delete();
      exp_addr.delete();
      dut_recv.delete();
      resp_data.delete();
      req_count = 0;
      for (int i = 0; i < int'(n); i++) begin
         a = b + AW'(i * int'(s));
         exp_addr.push_back(a);
         resp_data.push_back(data0 + 16'(i));
      end
      @(negedge clk);
      base_addr = b;
      cuenta    = n;
      stride    = s;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      int d0;
      bit ok;
      d0 = done_count;
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk);
         #1;
         if (done_count != d0) ok = 1'b1;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic check_addrs(input string name);
      chk({name, "_nreq"}, 32'(addr_seen.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < addr_seen.size(); i++)
         chk({name, "_addr"}, 32'(addr_seen[i]), 32'(exp_addr[i]));
   endtask

   initial begin
      int d0;
      int p0;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      cuenta    = 16'd0;
      stride    = 8'd0;
      act_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req", 32'(cache_req), 32'd0);
      chk("rst_valid", 32'(act_valid), 32'd0);
      chk("rst_addr", 32'(cache_address), 32'd0);
      chk("rst_act_out", 32'(act_out), 32'd0);
      chk("rd_wr_tie", 32'(cache_lectura_escritura), 32'd1);
      rst = 1'b0;

      // Basic run.
      act_ready = 1'b1;
      d0 = done_count;
      launch(17'h00100, 16'd4, 8'd1, 16'h1111);
      resp_data.delete();
      for (int i = 1; i <= 4; i++) resp_data.push_back(16'(i) * 16'h1111);
      wait_done("basic_done", 60);
      repeat (3) @(negedge clk);
      check_addrs("basic");
      chk("basic_addr0", 32'(addr_seen[0]), 32'h00100);
      chk("basic_addr3", 32'(addr_seen[3]), 32'h00103);
      chk("basic_nwords", 32'(dut_recv.size()), 32'd4);
      chk("basic_w0", 32'(dut_recv[0]), 32'h1111);
      chk("basic_w1", 32'(dut_recv[1]), 32'h2222);
      chk("basic_w2", 32'(dut_recv[2]), 32'h3333);
      chk("basic_w3", 32'(dut_recv[3]), 32'h4444);
      chk("basic_done_once", 32'(done_count - d0), 32'd1);

      // Address wrap, with an ignored start pulse mid-run.
      launch(17'h1FFFE, 16'd3, 8'd3, 16'hA001);
      repeat (2) @(negedge clk);
      base_addr = 17'h00000;
      cuenta    = 16'd5;
      stride    = 8'd7;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("wrap_done", 60);
      repeat (3) @(negedge clk);
      check_addrs("wrap");
      chk("wrap_a0", 32'(addr_seen[0]), 32'h1FFFE);
      chk("wrap_a1", 32'(addr_seen[1]), 32'h00001);
      chk("wrap_a2", 32'(addr_seen[2]), 32'h00004);
      chk("wrap_nwords", 32'(dut_recv.size()), 32'd3);

      // Backpressure: buffer fills, requests stop, then release.
      act_ready = 1'b0;
      d0 = done_count;
      launch(17'h00200, 16'd8, 8'd2, 16'h0B01);
      repeat (40) @(negedge clk);
      chk("bp_stall_nreq", 32'(req_count), 32'd4);
      chk("bp_stall_req_low", 32'(cache_req), 32'd0);
      chk("bp_head", 32'(act_out), 32'h0B01);
      chk("bp_busy", 32'(busy), 32'd1);
      act_ready = 1'b1;
      wait_done("bp_done", 200);
      repeat (3) @(negedge clk);
      check_addrs("bp");
      chk("bp_nwords", 32'(dut_recv.size()), 32'd8);
      for (int i = 0; i < 8 && i < dut_recv.size(); i++)
         chk("bp_word", 32'(dut_recv[i]), 32'h0B01 + 32'(i));
      chk("bp_done_once", 32'(done_count - d0), 32'd1);

      // Zero-length run.
      launch(17'h00400, 16'd0, 8'd1, 16'h0000);
      wait_done("zero_done", 10);
      chk("zero_latency", 32'(done_cyc - start_cyc), 32'd2);
      chk("zero_nreq", 32'(req_count), 32'd0);
      chk("zero_busy_after", 32'(busy), 32'd0);

      // Abort in WAIT with two words buffered; late response must be dropped.
      act_ready = 1'b0;
      d0 = done_count;
      launch(17'h00300, 16'd4, 8'd4, 16'h00C1);
      for (int i = 0; i < 50 && req_count < 3; i++) @(negedge clk);
      chk("abort_reached", 32'(req_count), 32'd3);
      chk("abort_buffered", 32'(model_q.size()), 32'd2);
      p0 = pulses;
      ignore_resp = 1'b1;
      rst = 1'b1;
      #1;
      chk("abort_valid_drop", 32'(act_valid), 32'd0);
      chk("abort_busy_drop", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_late_pulse_sent", 32'(pulses - p0), 32'd1);
      chk("abort_no_push", 32'(act_valid), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_no_req", 32'(req_count), 32'd3);
      chk("abort_no_done", 32'(done_count - d0), 32'd0);
      ignore_resp = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

endmodule
